axis_read_sched: RTL and testbench
==================================

Name: axis_read_sched

Overview:
- Shares one axis_read engine among NUM_REQ requesters, each supplying a read descriptor (start address, stream length).
- Arbitrates round-robin and drives the engine's cfg bus with the three-word configuration sequence.
- Counts beats accepted on the engine's output stream to detect when the transfer is complete.
- Pulses a per-requester done, then serves the next request. Sits between the control/host logic and axis_read's cfg_* inputs.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
CONFIG_ID, 1, ID word the engine matches
CONFIG_ADDR, 23, cfg address of the engine's select register
CONFIG_DATA, 24, cfg address of the engine's data register
CONFIG_AWIDTH, 5, cfg address width
CONFIG_DWIDTH, 32, cfg data, address and length width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester descriptor valid
req_ready  out  NUM_REQ  per-requester descriptor accepted (one-hot, 1 cycle)
req_addr  in  NUM_REQ*CONFIG_DWIDTH  packed start addresses, requester i at [i*DW +: DW]
req_len  in  NUM_REQ*CONFIG_DWIDTH  packed lengths in stream words
req_done  out  NUM_REQ  one-hot 1-cycle pulse when requester's stream finished
cfg_addr  out  CONFIG_AWIDTH  to engine
cfg_data  out  CONFIG_DWIDTH  to engine
cfg_valid  out  1  to engine
str_valid  in  1  tap of engine output valid
str_ready  in  1  tap of engine output ready
busy  out  1  high in any state other than IDLE
grant  out  $clog2(NUM_REQ) (min 1)  index of current/last granted requester

Behaviour:
- Reset values: req_ready=0, req_done=0, cfg_valid=0, cfg_addr=0, cfg_data=0, busy=0, grant=0, rr pointer=0, beat count=0, state=IDLE.
- All outputs registered; rst overrides everything the same cycle, including mid-sequence/mid-stream. Engine shares rst, so no cleanup is sent.
- States (one-hot): IDLE, GRANT, CFG_ID, CFG_ADDR, CFG_LEN, RUN, DONE.
- IDLE: if any req_valid, pick the first set bit searching from rr pointer upward with wrap; go to GRANT.
- GRANT: pulse req_ready[g] for one cycle. Latch addr/len of g into internal registers; set grant=g; rr pointer = g+1 mod NUM_REQ.
  - If len==0: go to DONE directly; no cfg writes are issued.
  - Otherwise go to CFG_ID.
- CFG_ID: cfg_valid=1, cfg_addr=CONFIG_ADDR, cfg_data=CONFIG_ID.
- CFG_ADDR: cfg_valid=1, cfg_addr=CONFIG_DATA, cfg_data=latched addr.
- CFG_LEN: cfg_valid=1, cfg_addr=CONFIG_DATA, cfg_data=latched len.
- The three cfg words are on consecutive cycles (engine tolerates back-to-back). cfg_valid=0 in all other states; cfg_addr/cfg_data hold their last values.
- RUN:
  - Beat counter (CONFIG_DWIDTH bits), cleared at GRANT, increments on str_valid&str_ready.
  - Handshakes seen during the CFG_* states are counted too; they belong to this transfer because the engine was idle before.
  - Go to DONE on the cycle the count reaches latched len, i.e. a handshake while count==len-1.
- DONE: pulse req_done[grant] for one cycle; go to IDLE. The next grant can occur 2 cycles after DONE.
- Request rule: a requester must hold req_valid and stable addr/len until its req_ready. Deasserting req_valid before grant withdraws the request.
- Simultaneous requests: strict round-robin from the pointer, so no requester is starved. With NUM_REQ=1 this degenerates to serial service.
- Length wrap: the counter never wraps because len < 2^DW is compared exactly. len=0xFFFFFFFF is legal.
- Descriptor latency: req_valid set in IDLE -> req_ready 1 cycle later -> first cfg_valid 2 cycles later.

Decomposition:
- Shared package:
  - state index constants (S_IDLE..S_DONE);
  - CONFIG_ID/ADDR/DATA defaults, common with axis_read/axis_write configuration.
- One sub-module: rr_arbiter (NUM_REQ request vector + pointer in, one-hot grant + valid out, purely combinational find-first-from-pointer). Reusable for an axis_write scheduler.

Test Plan:
- Single request r0 addr=0x1000 len=4 -> cfg sequence (23,1),(24,0x1000),(24,4) on 3 consecutive cycles; 4 str handshakes -> req_done[0] on the cycle after the 4th beat's state transition; busy returns 0.
- req_valid=4'b1111 held, len=2 each -> grant order 0,1,2,3. Then with r1 and r3 reissued after pointer=0, order is 1,3.
- req_len=0 on r2 -> req_ready[2] then req_done[2] 1 cycle later; cfg_valid never asserted.
- Stream backpressure (str_ready toggling 1,0,0,1 ...) len=5 -> done only after exactly 5 valid&ready cycles; valid-only cycles are not counted.
- rst asserted during RUN after 3 of 8 beats -> all outputs 0 next cycle. A new r1 request afterward is served from pointer 0 with count restarting at 0.
- Requester withdraws req_valid before grant while another is pending -> only the remaining requester is granted; no req_ready to the withdrawn one.

Source files
------------

// File: rtl/axis_read_sched_pkg.sv
// Shared definitions for the axis_read scheduler: engine cfg register map
// defaults, FSM state indices and the one-hot state type.
package axis_read_sched_pkg;

   localparam int unsigned DEF_CONFIG_ID     = 1;
   localparam int unsigned DEF_CONFIG_ADDR   = 23;
   localparam int unsigned DEF_CONFIG_DATA   = 24;
   localparam int unsigned DEF_CONFIG_AWIDTH = 5;
   localparam int unsigned DEF_CONFIG_DWIDTH = 32;

   localparam int unsigned S_IDLE     = 0;
   localparam int unsigned S_GRANT    = 1;
   localparam int unsigned S_CFG_ID   = 2;
   localparam int unsigned S_CFG_ADDR = 3;
   localparam int unsigned S_CFG_LEN  = 4;
   localparam int unsigned S_RUN      = 5;
   localparam int unsigned S_DONE     = 6;
   localparam int unsigned NUM_STATES = 7;

   typedef enum logic [NUM_STATES-1:0] {
      ST_IDLE     = 7'b1 << S_IDLE,
      ST_GRANT    = 7'b1 << S_GRANT,
      ST_CFG_ID   = 7'b1 << S_CFG_ID,
      ST_CFG_ADDR = 7'b1 << S_CFG_ADDR,
      ST_CFG_LEN  = 7'b1 << S_CFG_LEN,
      ST_RUN      = 7'b1 << S_RUN,
      ST_DONE     = 7'b1 << S_DONE
   } state_e;

   function automatic int unsigned grant_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_read_sched_if.sv
// Requester, engine-cfg and stream-tap signals of the axis_read scheduler.
// master = scheduler side, slave = requesters/engine side.
interface axis_read_sched_if
   import axis_read_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned CONFIG_AWIDTH = DEF_CONFIG_AWIDTH,
   parameter int unsigned CONFIG_DWIDTH = DEF_CONFIG_DWIDTH
);
   localparam int unsigned GW = grant_width(NUM_REQ);

   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_addr;
   logic [NUM_REQ*CONFIG_DWIDTH-1:0] req_len;
   logic [NUM_REQ-1:0]               req_done;
   logic [CONFIG_AWIDTH-1:0]         cfg_addr;
   logic [CONFIG_DWIDTH-1:0]         cfg_data;
   logic                             cfg_valid;
   logic                             str_valid;
   logic                             str_ready;
   logic                             busy;
   logic [GW-1:0]                    grant;

   modport master (
      input  req_valid, req_addr, req_len, str_valid, str_ready,
      output req_ready, req_done, cfg_addr, cfg_data, cfg_valid, busy, grant
   );

   modport slave (
      output req_valid, req_addr, req_len, str_valid, str_ready,
      input  req_ready, req_done, cfg_addr, cfg_data, cfg_valid, busy, grant
   );

endinterface

// File: rtl/axis_read_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Shared with the axis_write scheduler.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               valid
);

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!valid && req[(32'(ptr) + i) % NUM_REQ]) begin
            gnt[(32'(ptr) + i) % NUM_REQ] = 1'b1;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_read_sched.sv
// Round-robin scheduler sharing one axis_read engine among NUM_REQ requesters:
// grants a descriptor, writes the three cfg words, counts stream beats, pulses done.
module axis_read_sched
   import axis_read_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned CONFIG_ID     = DEF_CONFIG_ID,
   parameter int unsigned CONFIG_ADDR   = DEF_CONFIG_ADDR,
   parameter int unsigned CONFIG_DATA   = DEF_CONFIG_DATA,
   parameter int unsigned CONFIG_AWIDTH = DEF_CONFIG_AWIDTH,
   parameter int unsigned CONFIG_DWIDTH = DEF_CONFIG_DWIDTH
) (
   input logic               clk,
   input logic               rst,
   axis_read_sched_if.master bus
);

   localparam int unsigned GW = grant_width(NUM_REQ);
   localparam int unsigned AW = CONFIG_AWIDTH;
   localparam int unsigned DW = CONFIG_DWIDTH;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0] req_done_q, req_done_d;
   logic               cfg_valid_q, cfg_valid_d;
   logic [AW-1:0]      cfg_addr_q, cfg_addr_d;
   logic [DW-1:0]      cfg_data_q, cfg_data_d;
   logic [DW-1:0]      addr_q, addr_d;
   logic [DW-1:0]      len_q, len_d;
   logic [DW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [GW-1:0]      ptr_q, ptr_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic               arb_valid;
   logic [GW-1:0]      arb_idx;
   logic               beat;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (GW)
   ) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .valid (arb_valid)
   );

   always_comb begin
      arb_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) arb_idx = GW'(i);
      end
   end

   assign beat = bus.str_valid & bus.str_ready;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               state_d = ST_GRANT;
               grant_d = arb_idx;
               ptr_d   = (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + GW'(1);
               addr_d  = bus.req_addr[arb_idx*DW +: DW];
               len_d   = bus.req_len[arb_idx*DW +: DW];
            end
         end
         ST_GRANT: begin
            cnt_d   = '0;
            state_d = (len_q == '0) ? ST_DONE : ST_CFG_ID;
         end
         // The engine was idle before, so beats seen while configuring belong here.
         ST_CFG_ID: begin
            if (beat) cnt_d = cnt_q + DW'(1);
            state_d = ST_CFG_ADDR;
         end
         ST_CFG_ADDR: begin
            if (beat) cnt_d = cnt_q + DW'(1);
            state_d = ST_CFG_LEN;
         end
         ST_CFG_LEN: begin
            if (beat) cnt_d = cnt_q + DW'(1);
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (beat) cnt_d = cnt_q + DW'(1);
            if (cnt_d == len_q) state_d = ST_DONE;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      req_ready_d = '0;
      req_done_d  = '0;
      cfg_valid_d = 1'b0;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      busy_d      = (state_d != ST_IDLE);
      unique case (state_d)
         ST_GRANT: req_ready_d[grant_d] = 1'b1;
         ST_CFG_ID: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = AW'(CONFIG_ADDR);
            cfg_data_d  = DW'(CONFIG_ID);
         end
         ST_CFG_ADDR: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = AW'(CONFIG_DATA);
            cfg_data_d  = addr_d;
         end
         ST_CFG_LEN: begin
            cfg_valid_d = 1'b1;
            cfg_addr_d  = AW'(CONFIG_DATA);
            cfg_data_d  = len_d;
         end
         ST_DONE:  req_done_d[grant_d] = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         req_ready_q <= '0;
         req_done_q  <= '0;
         cfg_valid_q <= 1'b0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         grant_q     <= '0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         req_done_q  <= req_done_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         grant_q     <= grant_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.req_done  = req_done_q;
   assign bus.cfg_valid = cfg_valid_q;
   assign bus.cfg_addr  = cfg_addr_q;
   assign bus.cfg_data  = cfg_data_q;
   assign bus.busy      = busy_q;
   assign bus.grant     = grant_q;

endmodule

// File: tb/tb_axis_read_sched.sv
// Directed bench for axis_read_sched: reset, cfg sequence, round-robin order,
// zero length, backpressure, mid-run reset and request withdrawal.
module tb_axis_read_sched;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   axis_read_sched_if #(
      .NUM_REQ       (4),
      .CONFIG_AWIDTH (5),
      .CONFIG_DWIDTH (32)
   ) bus ();

   axis_read_sched #(
      .NUM_REQ       (4),
      .CONFIG_ID     (1),
      .CONFIG_ADDR   (23),
      .CONFIG_DATA   (24),
      .CONFIG_AWIDTH (5),
      .CONFIG_DWIDTH (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.req_ready != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic drive_beats(input int n);
      bus.str_valid = 1'b1;
      bus.str_ready = 1'b1;
      repeat (n) tick();
      bus.str_valid = 1'b0;
      bus.str_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({bus.req_ready, bus.req_done} !== 8'h00) begin
         failures++;
         $display("FAIL reset_req got %b exp 00000000", {bus.req_ready, bus.req_done});
      end
      checks++;
      if ({bus.cfg_valid, bus.cfg_addr, bus.cfg_data} !== 38'h0) begin
         failures++;
         $display("FAIL reset_cfg got %h exp 0", {bus.cfg_valid, bus.cfg_addr, bus.cfg_data});
      end
      checks++;
      if ({bus.busy, bus.grant} !== 3'b000) begin
         failures++;
         $display("FAIL reset_busy_grant got %b exp 000", {bus.busy, bus.grant});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      bus.req_addr[31:0] = 32'h0000_1000;
      bus.req_len[31:0]  = 32'd4;
      bus.req_valid      = 4'b0001;
      tick();
      checks++;
      if ({bus.req_ready, bus.busy, bus.grant} !== 7'b0001_1_00) begin
         failures++;
         $display("FAIL single_ready got %b exp 0001100", {bus.req_ready, bus.busy, bus.grant});
      end
      bus.req_valid = 4'b0000;
      tick();
      checks++;
      if ({bus.cfg_valid, bus.cfg_addr, bus.cfg_data} !== {1'b1, 5'd23, 32'd1}) begin
         failures++;
         $display("FAIL single_cfg_id got %h exp %h", {bus.cfg_valid, bus.cfg_addr, bus.cfg_data}, {1'b1, 5'd23, 32'd1});
      end
      tick();
      checks++;
      if ({bus.cfg_valid, bus.cfg_addr, bus.cfg_data} !== {1'b1, 5'd24, 32'h1000}) begin
         failures++;
         $display("FAIL single_cfg_addr got %h exp %h", {bus.cfg_valid, bus.cfg_addr, bus.cfg_data}, {1'b1, 5'd24, 32'h1000});
      end
      tick();
      checks++;
      if ({bus.cfg_valid, bus.cfg_addr, bus.cfg_data} !== {1'b1, 5'd24, 32'd4}) begin
         failures++;
         $display("FAIL single_cfg_len got %h exp %h", {bus.cfg_valid, bus.cfg_addr, bus.cfg_data}, {1'b1, 5'd24, 32'd4});
      end
      tick();
      checks++;
      if ({bus.cfg_valid, bus.cfg_addr, bus.cfg_data, bus.busy} !== {1'b0, 5'd24, 32'd4, 1'b1}) begin
         failures++;
         $display("FAIL single_cfg_hold got %h exp %h", {bus.cfg_valid, bus.cfg_addr, bus.cfg_data, bus.busy}, {1'b0, 5'd24, 32'd4, 1'b1});
      end
      bus.str_valid = 1'b1;
      bus.str_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (bus.req_done !== 4'b0000) begin
            failures++;
            $display("FAIL single_early_done beat=%0d got %b exp 0000", k + 1, bus.req_done);
         end
      end
      tick();
      bus.str_valid = 1'b0;
      bus.str_ready = 1'b0;
      checks++;
      if (bus.req_done !== 4'b0001) begin
         failures++;
         $display("FAIL single_done got %b exp 0001", bus.req_done);
      end
      tick();
      checks++;
      if ({bus.req_done, bus.busy} !== 5'b0000_0) begin
         failures++;
         $display("FAIL single_idle got %b exp 00000", {bus.req_done, bus.busy});
      end
   endtask

   task automatic test_round_robin();
      bit         ok;
      logic [3:0] exp;
      logic [1:0] exp_g;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.req_addr[i*32 +: 32] = 32'h2000 + i * 16;
         bus.req_len[i*32 +: 32]  = 32'd2;
      end
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) bus.req_valid = 4'b1010;
         exp   = (k < 4) ? (4'b0001 << k) : ((k == 4) ? 4'b0010 : 4'b1000);
         exp_g = (k < 4) ? 2'(k) : ((k == 4) ? 2'd1 : 2'd3);
         wait_ready(ok);
         checks++;
         if (!ok || bus.req_ready !== exp || bus.grant !== exp_g) begin
            failures++;
            $display("FAIL rr_grant k=%0d got ready=%b grant=%0d exp ready=%b grant=%0d", k, bus.req_ready, bus.grant, exp, exp_g);
         end
         bus.req_valid = bus.req_valid & ~exp;
         repeat (4) tick();
         drive_beats(2);
         checks++;
         if (bus.req_done !== exp) begin
            failures++;
            $display("FAIL rr_done k=%0d got %b exp %b", k, bus.req_done, exp);
         end
         tick();
      end
   endtask

   task automatic test_zero_len();
      bus.req_len[2*32 +: 32] = 32'd0;
      bus.req_valid = 4'b0100;
      tick();
      checks++;
      if ({bus.req_ready, bus.cfg_valid} !== 5'b0100_0) begin
         failures++;
         $display("FAIL zero_ready got %b exp 01000", {bus.req_ready, bus.cfg_valid});
      end
      bus.req_valid = 4'b0000;
      tick();
      checks++;
      if ({bus.req_done, bus.cfg_valid} !== 5'b0100_0) begin
         failures++;
         $display("FAIL zero_done got %b exp 01000", {bus.req_done, bus.cfg_valid});
      end
      tick();
      checks++;
      if ({bus.req_done, bus.cfg_valid, bus.busy} !== 6'b0000_0_0) begin
         failures++;
         $display("FAIL zero_idle got %b exp 000000", {bus.req_done, bus.cfg_valid, bus.busy});
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      logic [3:0] exp;
      bus.req_addr[31:0] = 32'h0000_3000;
      bus.req_len[31:0]  = 32'd5;
      bus.req_valid      = 4'b0001;
      wait_ready(ok);
      checks++;
      if (!ok || bus.req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL bp_ready got %b exp 0001", bus.req_ready);
      end
      bus.req_valid = 4'b0000;
      repeat (4) tick();
      for (int k = 0; k < 13; k++) begin
         bus.str_valid = 1'b1;
         bus.str_ready = (k % 3 == 0);
         tick();
         exp = (k == 12) ? 4'b0001 : 4'b0000;
         checks++;
         if (bus.req_done !== exp) begin
            failures++;
            $display("FAIL bp_done cycle=%0d got %b exp %b", k, bus.req_done, exp);
         end
      end
      bus.str_valid = 1'b0;
      bus.str_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset_midrun();
      bit ok;
      bus.req_addr[2*32 +: 32] = 32'h0000_4000;
      bus.req_len[2*32 +: 32]  = 32'd8;
      bus.req_valid            = 4'b0100;
      wait_ready(ok);
      checks++;
      if (!ok || bus.req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL mid_ready got %b exp 0100", bus.req_ready);
      end
      bus.req_valid = 4'b0000;
      repeat (4) tick();
      drive_beats(3);
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.req_ready, bus.req_done, bus.cfg_valid, bus.cfg_addr, bus.cfg_data, bus.busy, bus.grant} !== 49'h0) begin
         failures++;
         $display("FAIL mid_rst_outputs got %h exp 0", {bus.req_ready, bus.req_done, bus.cfg_valid, bus.cfg_addr, bus.cfg_data, bus.busy, bus.grant});
      end
      rst = 1'b0;
      bus.req_len[1*32 +: 32] = 32'd2;
      bus.req_len[3*32 +: 32] = 32'd2;
      bus.req_valid = 4'b1010;
      wait_ready(ok);
      checks++;
      if (!ok || bus.req_ready !== 4'b0010 || bus.grant !== 2'd1) begin
         failures++;
         $display("FAIL mid_regrant got ready=%b grant=%0d exp ready=0010 grant=1", bus.req_ready, bus.grant);
      end
      bus.req_valid = 4'b0000;
      repeat (4) tick();
      drive_beats(2);
      checks++;
      if (bus.req_done !== 4'b0010) begin
         failures++;
         $display("FAIL mid_count_restart got %b exp 0010", bus.req_done);
      end
      tick();
   endtask

   task automatic test_withdraw();
      bit ok;
      bus.req_len[3*32 +: 32] = 32'd2;
      bus.req_len[2*32 +: 32] = 32'd0;
      bus.req_valid = 4'b1000;
      wait_ready(ok);
      checks++;
      if (!ok || bus.req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL wd_first got %b exp 1000", bus.req_ready);
      end
      bus.req_valid = 4'b0101;
      repeat (4) tick();
      bus.req_valid = 4'b0100;
      drive_beats(2);
      checks++;
      if (bus.req_done !== 4'b1000) begin
         failures++;
         $display("FAIL wd_first_done got %b exp 1000", bus.req_done);
      end
      wait_ready(ok);
      checks++;
      if (!ok || bus.req_ready !== 4'b0100 || bus.grant !== 2'd2) begin
         failures++;
         $display("FAIL wd_remaining got ready=%b grant=%0d exp ready=0100 grant=2", bus.req_ready, bus.grant);
      end
      bus.req_valid = 4'b0000;
      tick();
      checks++;
      if (bus.req_done !== 4'b0100) begin
         failures++;
         $display("FAIL wd_remaining_done got %b exp 0100", bus.req_done);
      end
      tick();
      checks++;
      if ({bus.busy, bus.req_ready} !== 5'b0_0000) begin
         failures++;
         $display("FAIL wd_idle got %b exp 00000", {bus.busy, bus.req_ready});
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.str_valid = 1'b0;
      bus.str_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_zero_len();
      test_backpressure();
      test_reset_midrun();
      test_withdraw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
